// File: rtl/mopshub_test_sequencer.sv
// Test-phase sequencer: oscillator trim, sign-on wait, then a sweep over the
// enabled CAN buses running RX, TX, RX-then-TX or advanced phases.
module mopshub_test_sequencer #(
  parameter int N_BUS   = 16,
  parameter int BUS_W   = 5,
  parameter int TO_W    = 16,
  parameter int GAP_CYC = 120
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [BUS_W-1:0] n_buses,
  input  logic [N_BUS-1:0] bus_mask,
  input  logic [1:0]       mode,
  input  logic             loop,
  input  logic [TO_W-1:0]  timeout,
  input  logic             end_power_init,
  input  logic             sign_on_sig,
  input  logic             test_rx_end,
  input  logic             test_tx_end,
  input  logic             test_advanced_end,
  output logic             osc_auto_trim,
  output logic             test_rx,
  output logic             test_tx,
  output logic             test_advanced,
  output logic             endwait_all,
  output logic [BUS_W-1:0] bus_sel,
  output logic             busy,
  output logic             done,
  output logic             err_timeout,
  output logic [BUS_W-1:0] err_bus,
  output logic [15:0]      pass_cnt,
  output logic [3:0]       state_dbg
);

  // Handshake: each request level stays high until its end strobe is sampled
  // on a rising clk edge (or the phase times out); the strobe needs no ready.
  typedef enum logic [3:0] {
    S_IDLE, S_TRIM, S_WAIT_SIGN, S_FIND, S_RX, S_ENDWAIT,
    S_GAP, S_TX, S_ADV, S_NEXT, S_DONE
  } state_t;

  localparam int MW = 1 << BUS_W;
  localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [BUS_W-1:0] LAST     = BUS_W'(N_BUS - 1);
  localparam logic [GW-1:0]    GAP_LAST = GW'(GAP_CYC - 1);

  state_t            state, state_nx;
  logic [TO_W-1:0]   to_cnt;
  logic [GW-1:0]     gap_cnt;
  logic              any_found;
  logic [MW-1:0]     mask_ext;
  logic              in_phase, phase_end, expire;
  logic              eligible, at_last, start_run, restart;

  assign mask_ext  = MW'(bus_mask);
  assign state_dbg = state;

  always_comb begin
    in_phase  = (state == S_TRIM) || (state == S_RX) ||
                (state == S_TX) || (state == S_ADV);
    phase_end = ((state == S_TRIM) && end_power_init) ||
                ((state == S_RX)   && test_rx_end) ||
                ((state == S_TX)   && test_tx_end) ||
                ((state == S_ADV)  && test_advanced_end);
    // An end strobe in the expiry cycle wins, so no error is logged.
    expire    = in_phase && !phase_end && (timeout != '0) &&
                (to_cnt == timeout - TO_W'(1));
    eligible  = mask_ext[bus_sel] && (bus_sel < n_buses);
    at_last   = (bus_sel == LAST);
    start_run = ((state == S_IDLE) || (state == S_DONE)) && start;
    // A sweep that tested nothing must not loop forever.
    restart   = (state == S_NEXT) && at_last && loop && any_found;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE, S_DONE: if (start) state_nx = S_TRIM;
      S_TRIM: begin
        if (phase_end)   state_nx = S_WAIT_SIGN;
        else if (expire) state_nx = S_DONE;
      end
      S_WAIT_SIGN: if (sign_on_sig) state_nx = S_FIND;
      S_FIND: begin
        if (eligible) begin
          case (mode)
            2'b01:   state_nx = S_TX;
            2'b11:   state_nx = S_ADV;
            default: state_nx = S_RX;
          endcase
        end else if (at_last) begin
          state_nx = S_NEXT;
        end
      end
      S_RX: begin
        if (phase_end)   state_nx = S_ENDWAIT;
        else if (expire) state_nx = S_NEXT;
      end
      S_ENDWAIT: state_nx = (mode == 2'b10) ? S_GAP : S_NEXT;
      S_GAP:     if (gap_cnt == GAP_LAST) state_nx = S_TX;
      S_TX, S_ADV: if (phase_end || expire) state_nx = S_NEXT;
      S_NEXT: begin
        if (!at_last || restart) state_nx = S_FIND;
        else                     state_nx = S_DONE;
      end
      default: state_nx = S_IDLE;
    endcase
    if (abort) state_nx = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= S_IDLE;
      to_cnt        <= '0;
      gap_cnt       <= '0;
      any_found     <= 1'b0;
      bus_sel       <= '0;
      err_timeout   <= 1'b0;
      err_bus       <= '0;
      pass_cnt      <= '0;
      osc_auto_trim <= 1'b0;
      test_rx       <= 1'b0;
      test_tx       <= 1'b0;
      test_advanced <= 1'b0;
      endwait_all   <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      state         <= state_nx;
      osc_auto_trim <= (state_nx == S_TRIM);
      test_rx       <= (state_nx == S_RX);
      test_tx       <= (state_nx == S_TX);
      test_advanced <= (state_nx == S_ADV);
      endwait_all   <= (state_nx == S_ENDWAIT);
      busy          <= (state_nx != S_IDLE) && (state_nx != S_DONE);
      done          <= (state_nx == S_DONE);
      if (!abort) begin
        to_cnt  <= (state_nx != state) ? '0 : to_cnt + 1'b1;
        gap_cnt <= (state_nx != state) ? '0 : gap_cnt + 1'b1;
        if (start_run) begin
          bus_sel     <= '0;
          any_found   <= 1'b0;
          err_timeout <= 1'b0;
          err_bus     <= '0;
          pass_cnt    <= '0;
        end
        if (expire) begin
          err_timeout <= 1'b1;
          if (!err_timeout) err_bus <= bus_sel;
        end
        if (state == S_FIND) begin
          if (eligible)      any_found <= 1'b1;
          else if (!at_last) bus_sel   <= bus_sel + 1'b1;
        end
        if (state == S_NEXT) begin
          if (!at_last) begin
            bus_sel <= bus_sel + 1'b1;
          end else begin
            if (pass_cnt != 16'hFFFF) pass_cnt <= pass_cnt + 16'd1;
            if (restart) begin
              bus_sel   <= '0;
              any_found <= 1'b0;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_mopshub_test_sequencer.sv
// Bench for mopshub_test_sequencer: a responder answers phase requests, a
// monitor logs request events, and each run is compared with a sweep model.
module tb_mopshub_test_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0, abort = 1'b0, loop = 1'b0;
  logic [4:0]  n_buses = '0;
  logic [15:0] bus_mask = '0;
  logic [1:0]  mode = '0;
  logic [15:0] timeout = '0;
  logic        end_power_init = 1'b0, sign_on_sig = 1'b0;
  logic        test_rx_end = 1'b0, test_tx_end = 1'b0, test_advanced_end = 1'b0;
  logic        osc_auto_trim, test_rx, test_tx, test_advanced, endwait_all;
  logic [4:0]  bus_sel, err_bus;
  logic        busy, done, err_timeout;
  logic [15:0] pass_cnt;
  logic [3:0]  state_dbg;

  mopshub_test_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .n_buses(n_buses),
    .bus_mask(bus_mask), .mode(mode), .loop(loop), .timeout(timeout),
    .end_power_init(end_power_init), .sign_on_sig(sign_on_sig),
    .test_rx_end(test_rx_end), .test_tx_end(test_tx_end),
    .test_advanced_end(test_advanced_end), .osc_auto_trim(osc_auto_trim),
    .test_rx(test_rx), .test_tx(test_tx), .test_advanced(test_advanced),
    .endwait_all(endwait_all), .bus_sel(bus_sel), .busy(busy), .done(done),
    .err_timeout(err_timeout), .err_bus(err_bus), .pass_cnt(pass_cnt),
    .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // event = {phase, bus}; phase 0 rx, 1 tx, 2 advanced
  logic [6:0] exp_q[$];
  logic [6:0] act_q[$];
  int gap_q[$];
  int trim_q[$];
  int adv_q[$];
  int ew_cnt = 0;

  // responder configuration
  int resp_dly   = 20;
  bit resp_rand  = 1'b0;
  bit trim_hang  = 1'b0;
  int hang_phase = -1;
  int hang_bus   = -1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // responder: end strobe a programmable number of cycles after a request rises
  initial begin
    int  r_cnt[4];
    int  r_dly[4];
    bit  r_fired[4];
    bit  req[4];
    int  sign_cd;
    sign_cd = 0;
    for (int p = 0; p < 4; p++) begin r_cnt[p] = 0; r_dly[p] = 0; r_fired[p] = 0; end
    forever begin
      @(negedge clk);
      end_power_init = 1'b0; test_rx_end = 1'b0; test_tx_end = 1'b0;
      test_advanced_end = 1'b0; sign_on_sig = 1'b0;
      if (sign_cd > 0) begin
        sign_cd--;
        if (sign_cd == 0) sign_on_sig = 1'b1;
      end
      req[0] = osc_auto_trim; req[1] = test_rx; req[2] = test_tx; req[3] = test_advanced;
      for (int p = 0; p < 4; p++) begin
        if (!req[p]) begin
          r_cnt[p] = 0; r_fired[p] = 0;
        end else if (!r_fired[p]) begin
          if (r_cnt[p] == 0) r_dly[p] = resp_rand ? int'($urandom_range(1, 30)) : resp_dly;
          r_cnt[p]++;
          if (r_cnt[p] >= r_dly[p] && !((p == 0 && trim_hang) ||
              (p == hang_phase && int'(bus_sel) == hang_bus))) begin
            r_fired[p] = 1'b1;
            case (p)
              0: begin end_power_init = 1'b1; sign_cd = 5; end
              1: test_rx_end = 1'b1;
              2: test_tx_end = 1'b1;
              default: test_advanced_end = 1'b1;
            endcase
          end
        end
      end
    end
  end

  // monitor: request rises, endwait pulses, gap lengths, phase lengths
  initial begin
    bit p_rx, p_tx, p_adv, p_trim, gap_on;
    int gap_lo, trim_hi, adv_hi;
    p_rx = 0; p_tx = 0; p_adv = 0; p_trim = 0; gap_on = 0;
    gap_lo = 0; trim_hi = 0; adv_hi = 0;
    forever begin
      @(negedge clk);
      if (test_rx && !p_rx)       act_q.push_back({2'd0, bus_sel});
      if (test_tx && !p_tx)       act_q.push_back({2'd1, bus_sel});
      if (test_advanced && !p_adv) act_q.push_back({2'd2, bus_sel});
      if (endwait_all) begin
        ew_cnt++; gap_on = 1; gap_lo = 0;
      end else if (gap_on) begin
        if (test_tx) begin gap_q.push_back(gap_lo); gap_on = 0; end
        else if (test_rx || test_advanced || osc_auto_trim) gap_on = 0;
        else gap_lo++;
      end
      if (osc_auto_trim) trim_hi++;
      else if (p_trim) begin trim_q.push_back(trim_hi); trim_hi = 0; end
      if (test_advanced) adv_hi++;
      else if (p_adv) begin adv_q.push_back(adv_hi); adv_hi = 0; end
      p_rx = test_rx; p_tx = test_tx; p_adv = test_advanced; p_trim = osc_auto_trim;
    end
  end

  // reference sweep: every enabled slot below n_buses, in order
  task automatic build_exp(input logic [1:0] m, input int n, input logic [15:0] mk,
                           output int n_rx);
    n_rx = 0;
    exp_q.delete();
    for (int i = 0; i < 16; i++) begin
      if (mk[i] && i < n) begin
        case (m)
          2'b00: begin exp_q.push_back({2'd0, 5'(i)}); n_rx++; end
          2'b01: exp_q.push_back({2'd1, 5'(i)});
          2'b10: begin exp_q.push_back({2'd0, 5'(i)}); exp_q.push_back({2'd1, 5'(i)}); n_rx++; end
          default: exp_q.push_back({2'd2, 5'(i)});
        endcase
      end
    end
  endtask

  task automatic clear_logs();
    act_q.delete(); gap_q.delete(); trim_q.delete(); adv_q.delete();
    ew_cnt = 0;
  endtask

  task automatic setup(input logic [1:0] m, input int n, input logic [15:0] mk,
                       input logic lp, input logic [15:0] to);
    @(negedge clk);
    mode = m; n_buses = 5'(n); bus_mask = mk; loop = lp; timeout = to;
    clear_logs();
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int max_cyc);
    int k;
    k = 0;
    while (!done && k < max_cyc) begin @(negedge clk); k++; end
    chk({tag, "_done"}, done, 1'b1);
  endtask

  task automatic cmp_events(input string tag);
    chk({tag, "_ev_count"}, act_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < act_q.size(); i++)
      chk($sformatf("%s_ev%0d", tag, i), act_q[i], exp_q[i]);
  endtask

  initial begin
    int n_rx, n, k;
    logic [1:0]  m;
    logic [15:0] mk;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_outs", {osc_auto_trim, test_rx, test_tx, test_advanced, endwait_all, done}, 6'd0);
    chk("rst_bus_sel", bus_sel, 5'd0);
    chk("rst_err", {err_timeout, err_bus}, 6'd0);
    chk("rst_pass_cnt", pass_cnt, 16'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_idle", {busy, done, osc_auto_trim}, 3'd0);

    // RX over buses 0..2, strobes 20 cycles after each request
    resp_rand = 1'b0; resp_dly = 20;
    setup(2'b00, 3, 16'hFFFF, 1'b0, 16'd0);
    build_exp(2'b00, 3, 16'hFFFF, n_rx);
    pulse_start();
    chk("t1_busy", busy, 1'b1);
    wait_done("t1", 5000);
    cmp_events("t1");
    chk("t1_endwait", ew_cnt, n_rx);
    chk("t1_pass_cnt", pass_cnt, 16'd1);
    chk("t1_no_err", err_timeout, 1'b0);

    // RX then TX on buses 0 and 2 with the idle gap
    setup(2'b10, 16, 16'h0005, 1'b0, 16'd0);
    build_exp(2'b10, 16, 16'h0005, n_rx);
    pulse_start();
    wait_done("t2", 5000);
    cmp_events("t2");
    chk("t2_endwait", ew_cnt, n_rx);
    chk("t2_gap_count", gap_q.size(), 2);
    for (int i = 0; i < gap_q.size(); i++) chk($sformatf("t2_gap%0d", i), gap_q[i], 120);

    // advanced, bus 1 never answers, timeout 50
    hang_phase = 3; hang_bus = 1; resp_dly = 10;
    setup(2'b11, 3, 16'hFFFF, 1'b0, 16'd50);
    build_exp(2'b11, 3, 16'hFFFF, n_rx);
    pulse_start();
    wait_done("t3", 5000);
    cmp_events("t3");
    chk("t3_err_timeout", err_timeout, 1'b1);
    chk("t3_err_bus", err_bus, 5'd1);
    chk("t3_adv_lengths", adv_q.size(), 3);
    if (adv_q.size() == 3) chk("t3_adv_to_len", adv_q[1], 50);
    hang_phase = -1; hang_bus = -1;

    // zero eligible buses with loop set must still finish once
    setup(2'b00, 0, 16'hFFFF, 1'b1, 16'd0);
    pulse_start();
    wait_done("t4", 2000);
    chk("t4_pass_cnt", pass_cnt, 16'd1);
    chk("t4_no_err", err_timeout, 1'b0);
    chk("t4_no_events", act_q.size(), 0);
    repeat (5) @(negedge clk);
    chk("t4_stays_done", done, 1'b1);

    // randomized sweeps, with a stray start while busy
    resp_rand = 1'b1;
    for (int it = 0; it < 6; it++) begin
      m = 2'($urandom_range(0, 3));
      n = $urandom_range(0, 16);
      mk = 16'($urandom);
      setup(m, n, mk, 1'b0, 16'd0);
      build_exp(m, n, mk, n_rx);
      pulse_start();
      repeat (30) @(negedge clk);
      if (busy) begin start = 1'b1; @(negedge clk); start = 1'b0; end
      wait_done($sformatf("rnd%0d", it), 10000);
      cmp_events($sformatf("rnd%0d", it));
      chk($sformatf("rnd%0d_endwait", it), ew_cnt, n_rx);
      chk($sformatf("rnd%0d_pass_cnt", it), pass_cnt, 16'd1);
      chk($sformatf("rnd%0d_no_err", it), err_timeout, 1'b0);
      for (int i = 0; i < gap_q.size(); i++)
        chk($sformatf("rnd%0d_gap%0d", it, i), gap_q[i], 120);
    end

    // looping sweep over 2 buses, aborted during the third sweep
    resp_rand = 1'b0; resp_dly = 5;
    setup(2'b00, 2, 16'hFFFF, 1'b1, 16'd0);
    pulse_start();
    k = 0;
    while (pass_cnt != 16'd2 && k < 5000) begin @(negedge clk); k++; end
    chk("t5_two_sweeps", pass_cnt, 16'd2);
    k = 0;
    while (!test_rx && k < 500) begin @(negedge clk); k++; end
    chk("t5_third_sweep_rx", test_rx, 1'b1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("t5_reqs_low", {osc_auto_trim, test_rx, test_tx, test_advanced, endwait_all}, 5'd0);
    chk("t5_idle", {busy, done}, 2'b00);
    chk("t5_pass_cnt", pass_cnt, 16'd2);

    // trim never completes, timeout 100
    trim_hang = 1'b1;
    setup(2'b00, 3, 16'hFFFF, 1'b0, 16'd100);
    pulse_start();
    wait_done("t6", 2000);
    chk("t6_trim_count", trim_q.size(), 1);
    if (trim_q.size() == 1) chk("t6_trim_len", trim_q[0], 100);
    chk("t6_err_timeout", err_timeout, 1'b1);
    chk("t6_err_bus", err_bus, 5'd0);
    chk("t6_pass_cnt", pass_cnt, 16'd0);
    trim_hang = 1'b0;

    // asynchronous reset while test_tx is high
    hang_phase = 2; hang_bus = 0;
    setup(2'b01, 1, 16'h0001, 1'b0, 16'd0);
    pulse_start();
    k = 0;
    while (!test_tx && k < 500) begin @(negedge clk); k++; end
    chk("t7_tx_up", test_tx, 1'b1);
    #2 rst = 1'b0;
    #1;
    chk("t7_tx_async_drop", test_tx, 1'b0);
    chk("t7_busy_async_drop", busy, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    hang_phase = -1; hang_bus = -1;
    clear_logs();
    build_exp(2'b01, 1, 16'h0001, n_rx);
    pulse_start();
    chk("t7_restart_trim", osc_auto_trim, 1'b1);
    wait_done("t7", 2000);
    cmp_events("t7");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mopshub_test_sequencer.md
# mopshub_test_sequencer

Parametrised test-phase sequencer for the MOPSHUB verification environment. It replaces the ad-hoc per-bench control process with a single reusable block. It drives oscillator auto-trim, waits for sign-on, then walks a configurable set of CAN buses through RX, TX or advanced test phases, handshaking with the environment's start/end strobes. It sits between the bench top and the `mopshub_tb_environment`, generalising from a fixed 16-bus, single-bus flow to N buses with masking, looping, per-phase timeouts and error capture.

## Interface
Parameters:
- N_BUS, 16, number of bus slots (1..32)
- BUS_W, 5, width of bus index
- TO_W, 16, width of timeout counter
- GAP_CYC, 120, idle cycles between RX end and TX start (rx_tx mode)

Ports (clock and reset first):
- clk  in  1  sequencer clock (40 MHz bench clock)
- rst  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; starts a run from IDLE, ignored otherwise
- abort  in  1  synchronous abort; returns to IDLE from any state
- n_buses  in  BUS_W  number of populated buses; slots >= n_buses are skipped
- bus_mask  in  N_BUS  1 = bus enabled for test
- mode  in  2  00 rx, 01 tx, 10 rx_then_tx, 11 advanced
- loop  in  1  1 = restart sweep after last bus
- timeout  in  TO_W  per-phase cycle limit; 0 disables
- end_power_init  in  1  trim/power-init complete strobe
- sign_on_sig  in  1  hub sign-on strobe
- test_rx_end, test_tx_end, test_advanced_end  in  1 each  phase-complete strobes
- osc_auto_trim  out  1  trim request level
- test_rx, test_tx, test_advanced  out  1 each  phase request levels
- endwait_all  out  1  one-cycle pulse after each RX phase
- bus_sel  out  BUS_W  bus under test
- busy  out  1  high outside IDLE/DONE
- done  out  1  high in DONE
- err_timeout  out  1  sticky; set on any phase timeout
- err_bus  out  BUS_W  bus index of first timeout
- pass_cnt  out  16  completed sweeps, saturating at 16'hFFFF

## Operation
- States: IDLE, TRIM, WAIT_SIGN, FIND, RX, ENDWAIT, GAP, TX, ADV, NEXT, DONE.
- IDLE: start -> TRIM. On entry, err_timeout, err_bus and pass_cnt clear, and bus_sel = 0.
- TRIM: osc_auto_trim = 1. end_power_init -> WAIT_SIGN, with osc_auto_trim dropping in the same registered update.
- WAIT_SIGN: sign_on_sig -> FIND.
- FIND: scans upward from bus_sel for an index i with bus_mask[i] = 1 and i < n_buses, one index per cycle.
  - Found: load bus_sel. mode 00/10 -> RX, 01 -> TX, 11 -> ADV.
  - No eligible bus remains: go to NEXT-end handling.
- RX: test_rx = 1. test_rx_end -> ENDWAIT.
- ENDWAIT: endwait_all = 1 for exactly one cycle. mode 10 -> GAP, else -> NEXT.
- GAP: counts GAP_CYC cycles -> TX.
- TX: test_tx = 1. test_tx_end -> NEXT.
- ADV: test_advanced = 1. test_advanced_end -> NEXT.
- Timeout: a counter clears on entry to TRIM/RX/TX/ADV. If timeout != 0 and the counter reaches timeout:
  - err_timeout sets.
  - err_bus is loaded only if err_timeout was previously 0.
  - Phase request drops. RX/TX/ADV -> NEXT; TRIM -> DONE.
- NEXT:
  - bus_sel < N_BUS-1: increment bus_sel -> FIND.
  - Last slot reached: pass_cnt increments (saturating). loop = 1 -> bus_sel = 0, FIND; loop = 0 -> DONE.
- DONE: outputs hold. start -> TRIM (same as from IDLE).
- abort in any state -> IDLE next cycle. All request outputs go low and counters freeze.
- Zero eligible buses (n_buses = 0 or mask = 0): FIND falls through to sweep end.
  - loop = 0 -> DONE with pass_cnt = 1.
  - loop = 1 does not spin: stays in DONE and err_timeout stays clear.

## Timing
- All outputs are registered. Reset values: all 1-bit outputs 0, bus_sel 0, err_bus 0, pass_cnt 0.
- A request level asserts the cycle after state entry and deasserts the cycle after the end strobe is sampled.
- An end strobe arriving in the same cycle as the timeout compare takes priority; no error is recorded.
- abort has priority over every other transition; start is ignored while busy.
- FIND latency: 1 + number of skipped indices, in cycles.
- GAP: exactly GAP_CYC cycles with all request outputs low between endwait_all and test_tx rising.
- Asynchronous reset mid-phase drops every request output immediately, without waiting for a clock edge.

## Test plan
- mode 00, n_buses 3, mask all 1s, loop 0; end strobes 20 cycles after each request:
  - test_rx pulses for bus_sel 0, 1, 2.
  - endwait_all pulses 3 times.
  - done = 1, pass_cnt = 1.
- mode 10, mask 16'h0005, n_buses 16:
  - Only buses 0 and 2 are tested.
  - test_tx rises exactly 120 cycles after each endwait_all.
- mode 11, timeout 50, bus 1 never returns test_advanced_end:
  - err_timeout = 1, err_bus = 1.
  - Sequence continues to bus 2; final done = 1.
- loop 1, n_buses 2; abort at the 3rd sweep:
  - pass_cnt = 2.
  - FSM enters IDLE next cycle with all requests 0.
- end_power_init never arrives, timeout 100: osc_auto_trim falls after 100 cycles, err_timeout = 1, done = 1.
- rst asserted low while test_tx = 1: test_tx = 0 immediately; start after release runs from TRIM.
